seq_function_unit: RTL
======================

SEQ_FUNCTION_UNIT -- requirements
Module: seq_function_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (WIDTH >= 8).
REQ-002 SHALL have parameter SHW, default 5, meaning shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port CLK  input  1  rising-edge clock, the single clock.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  operation request; accepted only when BUSY=0.
REQ-006 SHALL have port FS  input  5  function select.
REQ-007 SHALL have ports A and B  input  WIDTH  operands.
REQ-008 SHALL have port SH  input  SHW  shift amount.
REQ-009 SHALL have port BUSY  output  1  high while an iterative operation is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse when F and the flags are updated.
REQ-011 SHALL have port F  output  WIDTH  registered result.
REQ-012 SHALL have ports Z_out, C_out, N_out, V_out  output  1 each  registered zero, carry, negative and overflow flags.

Function
REQ-013 SHALL capture FS, A, B and SH on the CLK edge at which START=1 and BUSY=0; operand changes after that edge SHALL NOT affect the operation.
REQ-014 SHALL decode FS single-cycle operations: 00000 A; 00001 A+1; 00010 A+B; 00011 A+B+1; 00100 A+~B; 00101 A+~B+1; 00110 A-1; 00111 A; 01000 A&B; 01010 A|B; 01100 A^B; 01110 ~A; 10000 B.
REQ-015 SHALL decode FS iterative operations: 10100 logical shift right of B by SH; 11000 logical shift left of B by SH; 11100 unsigned multiply A*B, keeping the low WIDTH bits in F.
REQ-016 SHALL treat any undefined FS code as F=A.
REQ-017 SHALL use FSM states IDLE and RUN: IDLE->RUN on accepting an iterative operation with non-zero count; RUN->IDLE when the count reaches 0.
REQ-018 SHALL have a latency L, counted from the accepting edge to the edge that writes F, of 1 for single-cycle operations, SH for shifts (1 if SH=0), and WIDTH for multiply.
REQ-019 SHALL perform shifts one bit per cycle and multiply as shift-add, one multiplier bit per cycle.
REQ-020 SHALL assert BUSY in every cycle strictly between acceptance and DONE, so BUSY is never high for operations with L=1.
REQ-021 SHALL drive DONE high for exactly one cycle following the write edge, and SHALL hold F and the flags unchanged until the next DONE.
REQ-022 SHALL ignore START while BUSY=1, and SHALL accept START in a DONE cycle (back-to-back operation).
REQ-023 SHALL set Z_out=(F==0) and N_out=F[WIDTH-1] for every operation.
REQ-024 SHALL set, for arithmetic codes 00001-00110, C_out to the adder carry-out and V_out to signed overflow of the operands as presented to the adder.
REQ-025 SHALL set, for shifts, C_out to the last bit shifted out (0 if SH=0) and V_out=0.
REQ-026 SHALL set, for multiply, C_out=1 if any product bit at or above WIDTH is non-zero, and V_out=0.
REQ-027 SHALL set C_out=0 and V_out=0 for logic, move and undefined codes.

Reset
REQ-028 SHALL, while RESET_N=0, immediately force state IDLE, BUSY=0, DONE=0, F=0 and all four flags to 0, regardless of CLK.
REQ-029 SHALL abandon an in-progress operation when reset is asserted mid-operation, with no DONE produced for it after reset is released.
REQ-030 SHALL ignore START until the first rising CLK edge after RESET_N returns high.

Verification (WIDTH=32)
REQ-031 SHALL be verified by: ADD, A=FFFFFFFF, B=00000001 -> after 1 cycle DONE=1, F=00000000, Z=1, C=1, N=0, V=0, and BUSY never high.
REQ-032 SHALL be verified by: SUB (00101), A=80000000, B=00000001 -> F=7FFFFFFF, V=1, C=1, N=0, Z=0.
REQ-033 SHALL be verified by: LSL, B=00000003, SH=31 -> BUSY high for 30 cycles, then DONE, F=80000000, C=1, N=1.
REQ-034 SHALL be verified by: MUL, A=B=00010000, with START pulsed again mid-BUSY -> a single DONE after 32 cycles, F=00000000, Z=1, C=1; the second START is ignored.
REQ-035 SHALL be verified by: XOR, A=F5F5F5F5, B=5F5F5F5F, issued in the DONE cycle of a prior operation -> accepted, next cycle DONE with F=AAAAAAAA, N=1.
REQ-036 SHALL be verified by: RESET_N low during a MUL at cycle 10 -> BUSY, DONE, F and flags all 0 immediately, and no DONE after release.

Source files
------------

// File: rtl/seq_function_unit.sv
// Sequential ALU: single-cycle arithmetic/logic, plus iterative shifts and shift-add multiply.
// Single-cycle ops finish at the accepting edge; shifts take SH steps and multiply takes WIDTH steps, one per clock, with START ignored while BUSY.
module seq_function_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   SH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] F,
  output logic             Z_out,
  output logic             C_out,
  output logic             N_out,
  output logic             V_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] OP_SHR = 2'd0;
  localparam logic [1:0] OP_SHL = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  logic [0:0]       state;
  logic [1:0]       op_r;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] a_r;

  logic             is_shr;
  logic             is_shl;
  logic             is_mul;
  logic             iter_go;
  logic [SHW-1:0]   steps_m1;

  assign is_shr   = (FS == 5'b10100);
  assign is_shl   = (FS == 5'b11000);
  assign is_mul   = (FS == 5'b11100);
  // A zero-length shift is a plain move of B and goes down the single-cycle path.
  assign iter_go  = is_mul || ((is_shr || is_shl) && (SH != '0));
  assign steps_m1 = is_mul ? SHW'(WIDTH - 1) : (SH - SHW'(1));

  assign BUSY = (state == RUN);

  // One iteration step; on the accepting edge it works straight from the inputs.
  logic [1:0]       op_s;
  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] nhi;
  logic [WIDTH-1:0] nlo;
  logic             step_c;

  always_comb begin
    op_s   = OP_SHR;
    hi_s   = '0;
    lo_s   = B;
    a_s    = A;
    addend = '0;
    msum   = '0;
    nhi    = '0;
    nlo    = '0;
    step_c = 1'b0;
    if (state == RUN) begin
      op_s = op_r;
      hi_s = hi_r;
      lo_s = lo_r;
      a_s  = a_r;
    end else if (is_mul) begin
      op_s = OP_MUL;
    end else if (is_shl) begin
      op_s = OP_SHL;
    end
    case (op_s)
      OP_MUL: begin
        addend = lo_s[0] ? a_s : '0;
        msum   = {1'b0, hi_s} + {1'b0, addend};
        nhi    = msum[WIDTH:1];
        nlo    = {msum[0], lo_s[WIDTH-1:1]};
        step_c = |nhi;
      end
      OP_SHL: begin
        nlo    = {lo_s[WIDTH-2:0], 1'b0};
        step_c = lo_s[WIDTH-1];
      end
      default: begin
        nlo    = {1'b0, lo_s[WIDTH-1:1]};
        step_c = lo_s[0];
      end
    endcase
  end

  // Single-cycle operations.
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             add_op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    add_op  = 1'b0;
    alu_f   = A;
    case (FS)
      5'b00001: begin add_op = 1'b1; add_cin = 1'b1; end
      5'b00010: begin add_op = 1'b1; add_y = B; end
      5'b00011: begin add_op = 1'b1; add_y = B; add_cin = 1'b1; end
      5'b00100: begin add_op = 1'b1; add_y = ~B; end
      5'b00101: begin add_op = 1'b1; add_y = ~B; add_cin = 1'b1; end
      5'b00110: begin add_op = 1'b1; add_y = '1; end
      5'b01000: alu_f = A & B;
      5'b01010: alu_f = A | B;
      5'b01100: alu_f = A ^ B;
      5'b01110: alu_f = ~A;
      5'b10000, 5'b10100, 5'b11000: alu_f = B;
      default:  alu_f = A;
    endcase
    add_sum = {1'b0, A} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (add_op) begin
      alu_f = add_sum[WIDTH-1:0];
      alu_c = add_sum[WIDTH];
      alu_v = (A[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    end
  end

  // Result write-back select.
  logic             use_step;
  logic             wr_en;
  logic [WIDTH-1:0] wr_f;
  logic             wr_c;
  logic             wr_v;

  always_comb begin
    use_step = (state == RUN) || iter_go;
    wr_en    = 1'b0;
    if (state == RUN) begin
      wr_en = (cnt == SHW'(1));
    end else if (START) begin
      wr_en = !iter_go || (steps_m1 == '0);
    end
    wr_f = use_step ? nlo    : alu_f;
    wr_c = use_step ? step_c : alu_c;
    wr_v = use_step ? 1'b0   : alu_v;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      op_r  <= OP_SHR;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      a_r   <= '0;
      DONE  <= 1'b0;
      F     <= '0;
      Z_out <= 1'b0;
      C_out <= 1'b0;
      N_out <= 1'b0;
      V_out <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == RUN) begin
        hi_r <= nhi;
        lo_r <= nlo;
        cnt  <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          state <= IDLE;
        end
      end else if (START && iter_go) begin
        hi_r <= nhi;
        lo_r <= nlo;
        a_r  <= A;
        op_r <= op_s;
        cnt  <= steps_m1;
        if (steps_m1 != '0) begin
          state <= RUN;
        end
      end
      if (wr_en) begin
        DONE  <= 1'b1;
        F     <= wr_f;
        Z_out <= (wr_f == '0);
        N_out <= wr_f[WIDTH-1];
        C_out <= wr_c;
        V_out <= wr_v;
      end
    end
  end

endmodule
